// File: rtl/sdram_cmd_responder.sv
// Device-side SDRAM command responder: decodes the controller's command bus, enforces
// init order and tRP/tRFC/tMRD/tRCD/tREFI timing, serves READ/WRITE and reports violations.
module sdram_cmd_responder #(
    parameter int T_RP   = 2,
    parameter int T_RFC  = 8,
    parameter int T_MRD  = 2,
    parameter int T_RCD  = 2,
    parameter int CL     = 2,
    parameter int T_REFI = 1024
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  cmd,
    input  logic [3:0]  addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic [3:0]  bank_open,
    output logic        init_done,
    output logic        busy,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [7:0]  err_count
);
    localparam int BMAX = (T_RP > T_RFC) ? ((T_RP > T_MRD) ? T_RP : T_MRD)
                                         : ((T_RFC > T_MRD) ? T_RFC : T_MRD);
    localparam int BW   = $clog2(BMAX + 1);
    localparam int RCW  = $clog2(T_RCD + 1);
    localparam int RW   = $clog2(T_REFI + 1);

    typedef enum logic [2:0] {W_PRE, W_REF1, W_REF2, W_MODE, READY} state_t;

    state_t          state_q, state_d;
    logic [3:0]      bank_open_q, bank_open_d;
    logic            init_done_q, init_done_d;
    logic [BW-1:0]   busy_cnt_q, busy_cnt_d;
    logic [RW-1:0]   refi_q, refi_d;
    logic            err_q, err_d;
    logic [2:0]      err_code_q, err_code_d;
    logic [7:0]      err_count_q, err_count_d;
    logic [RCW-1:0]  trcd_q [0:3];
    logic [CL-1:0]   vld_q;
    logic [15:0]     dat_q [0:CL-1];
    logic [15:0]     mem [0:63];

    logic            active, a10;
    logic [2:0]      op;
    logic [1:0]      ba;
    logic            is_act, is_rd, is_wr, is_pre, is_ref, is_lmr, is_rw, is_nop;
    logic            expected, accept, refi_hit;
    logic [2:0]      cmd_code;

    assign active = cmd[7] & ~cmd[6];
    assign op     = cmd[5:3];
    assign ba     = cmd[2:1];
    assign a10    = cmd[0];
    assign is_act = active && (op == 3'b011);
    assign is_rd  = active && (op == 3'b101);
    assign is_wr  = active && (op == 3'b100);
    assign is_pre = active && (op == 3'b010);
    assign is_ref = active && (op == 3'b001);
    assign is_lmr = active && (op == 3'b000);
    assign is_rw  = is_rd | is_wr;
    assign is_nop = ~(is_act | is_rw | is_pre | is_ref | is_lmr);

    // Command checking in priority order; a nonzero code drops the command.
    always_comb begin
        expected = 1'b0;
        cmd_code = 3'd0;
        case (state_q)
            W_PRE:          expected = is_pre & a10;
            W_REF1, W_REF2: expected = is_ref;
            W_MODE:         expected = is_lmr;
            default:        expected = 1'b0;
        endcase
        if (!is_nop) begin
            if (state_q != READY && !expected)
                cmd_code = 3'd1;
            else if (busy_cnt_q != '0)
                cmd_code = 3'd2;
            else if (state_q == READY) begin
                if (is_act && bank_open_q[ba])
                    cmd_code = 3'd3;
                else if (is_rw && !bank_open_q[ba])
                    cmd_code = 3'd4;
                else if (is_ref && (|bank_open_q))
                    cmd_code = 3'd6;
                else if (is_rw && (trcd_q[ba] != '0))
                    cmd_code = 3'd5;
            end
        end
    end

    assign accept   = !is_nop && (cmd_code == 3'd0);
    assign refi_hit = (state_q == READY) && (refi_q == RW'(T_REFI - 1)) && !(accept && is_ref);

    always_comb begin
        state_d     = state_q;
        bank_open_d = bank_open_q;
        busy_cnt_d  = (busy_cnt_q != '0) ? busy_cnt_q - 1'b1 : busy_cnt_q;
        refi_d      = refi_q;
        err_code_d  = err_code_q;
        err_count_d = err_count_q;
        if (accept) begin
            case (state_q)
                W_PRE:   state_d = W_REF1;
                W_REF1:  state_d = W_REF2;
                W_REF2:  state_d = W_MODE;
                W_MODE:  state_d = READY;
                default: state_d = state_q;
            endcase
            if (is_act)
                bank_open_d[ba] = 1'b1;
            if (is_pre && a10)
                bank_open_d = 4'b0000;
            if ((is_pre && !a10) || (is_rw && a10))
                bank_open_d[ba] = 1'b0;
            if (is_pre || (is_rw && a10))
                busy_cnt_d = BW'(T_RP - 1);
            if (is_ref)
                busy_cnt_d = BW'(T_RFC - 1);
            if (is_lmr)
                busy_cnt_d = BW'(T_MRD - 1);
        end
        if (accept && is_ref)
            refi_d = '0;
        else if (state_q == READY && refi_q != RW'(T_REFI))
            refi_d = refi_q + 1'b1;
        err_d = (cmd_code != 3'd0) || refi_hit;
        if (err_code_q == 3'd0)
            err_code_d = (cmd_code != 3'd0) ? cmd_code : (refi_hit ? 3'd7 : 3'd0);
        if (err_d && err_count_q != 8'hFF)
            err_count_d = err_count_q + 8'd1;
        init_done_d = (state_d == READY);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= W_PRE;
            bank_open_q <= 4'b0000;
            init_done_q <= 1'b0;
            busy_cnt_q  <= '0;
            refi_q      <= '0;
            err_q       <= 1'b0;
            err_code_q  <= 3'd0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            bank_open_q <= bank_open_d;
            init_done_q <= init_done_d;
            busy_cnt_q  <= busy_cnt_d;
            refi_q      <= refi_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_count_q <= err_count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_trcd
            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET)
                    trcd_q[gi] <= '0;
                else if (accept && is_act && ba == 2'(gi))
                    trcd_q[gi] <= RCW'(T_RCD - 1);
                else if (trcd_q[gi] != '0)
                    trcd_q[gi] <= trcd_q[gi] - 1'b1;
            end
        end
    endgenerate

    // Data path carries no reset; the output mux below presents zero whenever no strobe.
    always_ff @(posedge CLK) begin
        if (accept && is_wr)
            mem[{ba, addr}] <= wr_data;
        dat_q[0] <= mem[{ba, addr}];
        for (int i = 1; i < CL; i++)
            dat_q[i] <= dat_q[i-1];
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= accept && is_rd;
            for (int i = 1; i < CL; i++)
                vld_q[i] <= vld_q[i-1];
        end
    end

    assign rd_valid  = vld_q[CL-1];
    assign rd_data   = vld_q[CL-1] ? dat_q[CL-1] : 16'h0000;
    assign bank_open = bank_open_q;
    assign init_done = init_done_q;
    assign busy      = (busy_cnt_q != '0);
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign err_count = err_count_q;
endmodule
